saradc_sar_ctrl: RTL

SARADC_SAR_CTRL -- requirements
Module: saradc_sar_ctrl

---
 rtl/saradc_sar_ctrl.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/saradc_sar_ctrl.sv
// SAR ADC sequencer: precharge, sample hold, sign decision, then one 5-cycle CDAC trial per LSB bit.
// Define SARADC_SAR_CTRL_CONT_EN to loop DONE straight back into PRE (continuous conversion).
module saradc_sar_ctrl #(
    parameter int NBITS = 7,
    parameter int NPRE  = 2
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             START,
    input  logic             CMP,
    output logic             CMPEN,
    output logic             CPRE,
    output logic             CPREB,
    output logic             CHOLD,
    output logic             CHOLDB,
    output logic [NBITS-1:0] CRH,
    output logic [NBITS-1:0] CRHB,
    output logic [NBITS-1:0] CRL,
    output logic [NBITS-1:0] CRLB,
    output logic [NBITS:0]   DOUT,
    output logic             VALID,
    output logic             BUSY
);

    localparam int IDXW = (NBITS > 1) ? $clog2(NBITS) : 1;
    localparam int PW   = (NPRE > 1) ? $clog2(NPRE) : 1;

    typedef enum logic [3:0] {
        S_IDLE, S_PRE, S_NOV, S_HOLD, S_SIGN,
        S_BRK, S_MAKE, S_CMPS, S_DEC, S_FIX, S_DONE
    } state_t;

    state_t           state_reg;
    logic [PW-1:0]    pre_cnt_reg;
    logic [IDXW-1:0]  idx_reg;
    logic             cmpen_reg, cpre_reg, cpreb_reg, chold_reg, choldb_reg;
    logic [NBITS-1:0] crh_reg, crhb_reg, crl_reg, crlb_reg;
    logic [NBITS:0]   dout_reg;
    logic             valid_reg, busy_reg;

    // Each complement has its own flop so both polarities switch on the same edge.
    // Outputs are loaded together with the state they belong to, so the comparator
    // result is taken at the end of each strobe cycle (HOLD, CMPS).
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_reg   <= S_IDLE;
            pre_cnt_reg <= '0;
            idx_reg     <= '0;
            cmpen_reg   <= 1'b0;
            cpre_reg    <= 1'b0;
            cpreb_reg   <= 1'b1;
            chold_reg   <= 1'b0;
            choldb_reg  <= 1'b1;
            crh_reg     <= '0;
            crhb_reg    <= '1;
            crl_reg     <= '0;
            crlb_reg    <= '1;
            dout_reg    <= '0;
            valid_reg   <= 1'b0;
            busy_reg    <= 1'b0;
        end else begin
            valid_reg <= 1'b0;
            case (state_reg)
                S_IDLE: begin
                    if (START) begin
                        state_reg   <= S_PRE;
                        busy_reg    <= 1'b1;
                        pre_cnt_reg <= PW'(NPRE - 1);
                        cpre_reg    <= 1'b1;
                        cpreb_reg   <= 1'b0;
                    end
                end
                S_PRE: begin
                    if (pre_cnt_reg == '0) begin
                        state_reg <= S_NOV;
                        cpre_reg  <= 1'b0;
                        cpreb_reg <= 1'b1;
                        dout_reg  <= '0;
                    end else begin
                        pre_cnt_reg <= pre_cnt_reg - 1'b1;
                    end
                end
                S_NOV: begin
                    state_reg  <= S_HOLD;
                    chold_reg  <= 1'b1;
                    choldb_reg <= 1'b0;
                    crl_reg    <= '1;
                    crlb_reg   <= '0;
                    cmpen_reg  <= 1'b1;
                end
                S_HOLD: begin
                    state_reg       <= S_SIGN;
                    cmpen_reg       <= 1'b0;
                    dout_reg[NBITS] <= CMP;
                end
                S_SIGN: begin
                    state_reg          <= S_BRK;
                    idx_reg            <= IDXW'(NBITS - 1);
                    crl_reg[NBITS-1]   <= 1'b0;
                    crlb_reg[NBITS-1]  <= 1'b1;
                end
                S_BRK: begin
                    state_reg         <= S_MAKE;
                    crh_reg[idx_reg]  <= 1'b1;
                    crhb_reg[idx_reg] <= 1'b0;
                end
                S_MAKE: begin
                    state_reg <= S_CMPS;
                    cmpen_reg <= 1'b1;
                end
                S_CMPS: begin
                    state_reg         <= S_DEC;
                    cmpen_reg         <= 1'b0;
                    dout_reg[idx_reg] <= CMP;
                    if (!CMP) begin
                        crh_reg[idx_reg]  <= 1'b0;
                        crhb_reg[idx_reg] <= 1'b1;
                    end
                end
                S_DEC: begin
                    state_reg <= S_FIX;
                    if (!dout_reg[idx_reg]) begin
                        crl_reg[idx_reg]  <= 1'b1;
                        crlb_reg[idx_reg] <= 1'b0;
                    end
                end
                S_FIX: begin
                    if (idx_reg == '0) begin
                        state_reg  <= S_DONE;
                        valid_reg  <= 1'b1;
                        chold_reg  <= 1'b0;
                        choldb_reg <= 1'b1;
                    end else begin
                        state_reg                 <= S_BRK;
                        idx_reg                   <= idx_reg - 1'b1;
                        crl_reg[idx_reg - 1'b1]   <= 1'b0;
                        crlb_reg[idx_reg - 1'b1]  <= 1'b1;
                    end
                end
                S_DONE: begin
                    crh_reg  <= '0;
                    crhb_reg <= '1;
                    crl_reg  <= '0;
                    crlb_reg <= '1;
`ifdef SARADC_SAR_CTRL_CONT_EN
                    state_reg   <= S_PRE;
                    pre_cnt_reg <= PW'(NPRE - 1);
                    cpre_reg    <= 1'b1;
                    cpreb_reg   <= 1'b0;
`else
                    state_reg <= S_IDLE;
                    busy_reg  <= 1'b0;
`endif
                end
                default: begin
                    state_reg <= S_IDLE;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign CMPEN  = cmpen_reg;
    assign CPRE   = cpre_reg;
    assign CPREB  = cpreb_reg;
    assign CHOLD  = chold_reg;
    assign CHOLDB = choldb_reg;
    assign CRH    = crh_reg;
    assign CRHB   = crhb_reg;
    assign CRL    = crl_reg;
    assign CRLB   = crlb_reg;
    assign DOUT   = dout_reg;
    assign VALID  = valid_reg;
    assign BUSY   = busy_reg;

endmodule
